// File: rtl/result_reader_if.sv
// Producer/consumer handshake bundle for result_reader.
// The DUT side uses the slave modport; the bench or surrounding logic uses master.
interface result_reader_if #(
    parameter int CNT_W = 8
) ();
    logic [5:0]       i_data;
    logic             i_overflow;
    logic             i_valid;
    logic             o_ready;
    logic [5:0]       o_data;
    logic             o_overflow;
    logic             o_valid;
    logic             i_ready;
    logic [CNT_W-1:0] o_ovf_count;
    logic             o_drop;

    modport slave (
        input  i_data, i_overflow, i_valid, i_ready,
        output o_ready, o_data, o_overflow, o_valid, o_ovf_count, o_drop
    );

    modport master (
        output i_data, i_overflow, i_valid, i_ready,
        input  o_ready, o_data, o_overflow, o_valid, o_ovf_count, o_drop
    );
endinterface

// File: rtl/result_reader.sv
// First-word-fall-through FIFO for {overflow, data} result words, with a
// saturating overflow-event counter and a sticky drop flag for offers made while full.
module result_reader #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            i_rst,
    result_reader_if.slave  bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_OCC = (AW+1)'(DEPTH);

    logic [6:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             drop_q, drop_d;
    logic             ready, valid, push, pop;
    logic [6:0]       head;

    // Occupancy is one bit wider than the pointers, so full and empty never alias.
    assign ready = ~i_rst & (occ_q != FULL_OCC);
    assign valid = (occ_q != '0);
    assign push  = bus.i_valid & ready;
    assign pop   = valid & bus.i_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        ovf_cnt_d = ovf_cnt_q;
        drop_d    = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
        if (push && bus.i_overflow && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
        if (bus.i_valid && !ready) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            ovf_cnt_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            ovf_cnt_q <= ovf_cnt_d;
            drop_q    <= drop_d;
        end
    end

    // Storage is left uncleared; the head is masked whenever nothing is stored.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.i_overflow, bus.i_data};
        end
    end

    assign head            = valid ? mem_q[rd_ptr_q] : 7'd0;
    assign bus.o_ready     = ready;
    assign bus.o_valid     = valid;
    assign bus.o_data      = head[5:0];
    assign bus.o_overflow  = head[6];
    assign bus.o_ovf_count = ovf_cnt_q;
    assign bus.o_drop      = drop_q;
endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: a 4-deep/8-bit-counter instance for the
// data path and a 2-bit-counter instance for counter saturation.
module tb_result_reader;
    localparam int DEPTH = 4;

    logic clk;
    logic i_rst;

    result_reader_if #(.CNT_W(8)) u_if ();
    result_reader_if #(.CNT_W(2)) u_if2 ();

    result_reader #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (u_if.slave)
    );

    result_reader #(.DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (u_if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [6:0] exp_q [$];
    int         occ;
    int         exp_cnt;
    bit         exp_drop;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        occ      = 0;
        exp_cnt  = 0;
        exp_drop = 1'b0;
    endtask

    // Drives one cycle of stimulus on the main instance and advances the model.
    task automatic offer(input bit v, input logic [5:0] d, input bit ovf, input bit r,
                         output bit popping, output logic [6:0] head);
        bit pushing;
        u_if.i_valid    = v;
        u_if.i_data     = d;
        u_if.i_overflow = ovf;
        u_if.i_ready    = r;
        head    = 7'd0;
        popping = r && (occ > 0);
        pushing = v && (occ < DEPTH);
        if (popping) head = exp_q.pop_front();
        if (pushing) exp_q.push_back({ovf, d});
        if (v && occ == DEPTH) exp_drop = 1'b1;
        if (pushing && ovf && exp_cnt < 255) exp_cnt++;
        occ = occ + int'(pushing) - int'(popping);
    endtask

    task automatic do_reset();
        u_if.i_valid  = 1'b0;
        u_if.i_ready  = 1'b0;
        u_if2.i_valid = 1'b0;
        u_if2.i_ready = 1'b0;
        #2 i_rst = 1'b1;
        #2 i_rst = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic test_reset();
        #1;
        total_cnt++;
        if ({u_if.o_valid, u_if.o_ready, u_if.o_data, u_if.o_overflow, u_if.o_drop} !== 10'd0) begin
            $display("FAIL reset_outputs: got v=%0b r=%0b d=%h o=%0b drop=%0b, want all 0",
                     u_if.o_valid, u_if.o_ready, u_if.o_data, u_if.o_overflow, u_if.o_drop);
        end else pass_cnt++;
        total_cnt++;
        if (u_if.o_ovf_count !== 8'd0) begin
            $display("FAIL reset_count: got %0d want 0", u_if.o_ovf_count);
        end else pass_cnt++;
        #2 i_rst = 1'b0;
        tick();
        total_cnt++;
        if (u_if.o_ready !== 1'b1 || u_if.o_valid !== 1'b0) begin
            $display("FAIL reset_release: got ready=%0b valid=%0b want 1/0", u_if.o_ready, u_if.o_valid);
        end else pass_cnt++;
    endtask

    task automatic test_single();
        bit         p;
        logic [6:0] h;
        offer(1'b1, 6'h05, 1'b0, 1'b1, p, h);
        tick();
        total_cnt++;
        if (u_if.o_valid !== 1'b1 || u_if.o_data !== 6'h05 || u_if.o_overflow !== 1'b0) begin
            $display("FAIL single_latency: got v=%0b d=%h want v=1 d=05", u_if.o_valid, u_if.o_data);
        end else pass_cnt++;
        offer(1'b0, 6'h00, 1'b0, 1'b1, p, h);
        total_cnt++;
        if (!p || {u_if.o_overflow, u_if.o_data} !== h) begin
            $display("FAIL single_pop: got %h want %h (pop expected %0b)", {u_if.o_overflow, u_if.o_data}, h, p);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (u_if.o_valid !== 1'b0 || u_if.o_data !== 6'h00) begin
            $display("FAIL single_empty: got v=%0b d=%h want 0/00", u_if.o_valid, u_if.o_data);
        end else pass_cnt++;
        offer(1'b0, 6'h00, 1'b0, 1'b1, p, h);
        tick();
        total_cnt++;
        if (u_if.o_valid !== 1'b0 || u_if.o_ready !== 1'b1) begin
            $display("FAIL empty_pop_ignored: got v=%0b r=%0b want 0/1", u_if.o_valid, u_if.o_ready);
        end else pass_cnt++;
    endtask

    task automatic test_fill_drain();
        bit         p;
        logic [6:0] h;
        for (int i = 1; i <= 4; i++) begin
            offer(1'b1, 6'(i), i[0], 1'b0, p, h);
            tick();
        end
        total_cnt++;
        if (u_if.o_ready !== 1'b0 || u_if.o_drop !== 1'b0) begin
            $display("FAIL fill_full: got ready=%0b drop=%0b want 0/0", u_if.o_ready, u_if.o_drop);
        end else pass_cnt++;
        total_cnt++;
        if (u_if.o_ovf_count !== 8'(exp_cnt)) begin
            $display("FAIL fill_ovf_count: got %0d want %0d", u_if.o_ovf_count, exp_cnt);
        end else pass_cnt++;
        offer(1'b1, 6'h05, 1'b1, 1'b0, p, h);
        tick();
        total_cnt++;
        if (u_if.o_drop !== exp_drop || u_if.o_ovf_count !== 8'(exp_cnt)) begin
            $display("FAIL fill_drop: got drop=%0b cnt=%0d want %0b/%0d",
                     u_if.o_drop, u_if.o_ovf_count, exp_drop, exp_cnt);
        end else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            offer(1'b0, 6'h00, 1'b0, 1'b1, p, h);
            total_cnt++;
            if (!p || u_if.o_valid !== 1'b1 || {u_if.o_overflow, u_if.o_data} !== h) begin
                $display("FAIL drain_order[%0d]: got %h want %h", i, {u_if.o_overflow, u_if.o_data}, h);
            end else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (u_if.o_valid !== 1'b0 || u_if.o_drop !== 1'b1) begin
            $display("FAIL drain_end: got valid=%0b drop=%0b want 0/1", u_if.o_valid, u_if.o_drop);
        end else pass_cnt++;
    endtask

    task automatic test_full_pop();
        bit         p;
        logic [6:0] h;
        do_reset();
        total_cnt++;
        if (u_if.o_drop !== 1'b0) begin
            $display("FAIL full_pop_drop_cleared: got %0b want 0", u_if.o_drop);
        end else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 6'(6'h10 + i), 1'b0, 1'b0, p, h);
            tick();
        end
        offer(1'b1, 6'h3F, 1'b1, 1'b1, p, h);
        total_cnt++;
        if (!p || {u_if.o_overflow, u_if.o_data} !== h) begin
            $display("FAIL full_pop_head: got %h want %h", {u_if.o_overflow, u_if.o_data}, h);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (u_if.o_drop !== 1'b1 || u_if.o_ready !== 1'b1 || u_if.o_ovf_count !== 8'd0) begin
            $display("FAIL full_pop_state: got drop=%0b ready=%0b cnt=%0d want 1/1/0",
                     u_if.o_drop, u_if.o_ready, u_if.o_ovf_count);
        end else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            offer(1'b0, 6'h00, 1'b0, 1'b1, p, h);
            total_cnt++;
            if (!p || {u_if.o_overflow, u_if.o_data} !== h) begin
                $display("FAIL full_pop_drain[%0d]: got %h want %h", i, {u_if.o_overflow, u_if.o_data}, h);
            end else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (u_if.o_valid !== 1'b0) begin
            $display("FAIL full_pop_occupancy: got valid=%0b want 0 after 3 pops", u_if.o_valid);
        end else pass_cnt++;
    endtask

    task automatic test_stream();
        bit         p;
        logic [6:0] h;
        offer(1'b1, 6'h00, 1'b0, 1'b1, p, h);
        tick();
        for (int i = 1; i <= 10; i++) begin
            offer(i < 10, 6'(i), 1'b0, 1'b1, p, h);
            total_cnt++;
            if (!p || u_if.o_ready !== 1'b1 || {u_if.o_overflow, u_if.o_data} !== h) begin
                $display("FAIL stream[%0d]: got d=%h ready=%0b want d=%h ready=1",
                         i, {u_if.o_overflow, u_if.o_data}, u_if.o_ready, h);
            end else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (u_if.o_valid !== 1'b0 || exp_q.size() != 0) begin
            $display("FAIL stream_end: got valid=%0b left=%0d want 0/0", u_if.o_valid, exp_q.size());
        end else pass_cnt++;
    endtask

    task automatic test_saturation();
        int exp2 = 0;
        u_if2.i_data     = 6'h2A;
        u_if2.i_overflow = 1'b1;
        u_if2.i_ready    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            u_if2.i_valid = 1'b1;
            tick();
            if (exp2 < 3) exp2++;
            total_cnt++;
            if (u_if2.o_ovf_count !== 2'(exp2)) begin
                $display("FAIL sat_count[%0d]: got %0d want %0d", i, u_if2.o_ovf_count, exp2);
            end else pass_cnt++;
        end
        u_if2.i_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        bit         p;
        logic [6:0] h;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 6'(6'h20 + i), 1'b1, 1'b0, p, h);
            tick();
        end
        offer(1'b0, 6'h00, 1'b0, 1'b0, p, h);
        total_cnt++;
        if (u_if.o_valid !== 1'b1 || u_if.o_ovf_count !== 8'(exp_cnt)) begin
            $display("FAIL pre_reset: got valid=%0b cnt=%0d want 1/%0d", u_if.o_valid, u_if.o_ovf_count, exp_cnt);
        end else pass_cnt++;
        #2 i_rst = 1'b1;
        #1;
        total_cnt++;
        if ({u_if.o_valid, u_if.o_ready, u_if.o_data, u_if.o_overflow, u_if.o_drop} !== 10'd0 ||
            u_if.o_ovf_count !== 8'd0) begin
            $display("FAIL async_reset: got v=%0b r=%0b d=%h cnt=%0d drop=%0b want all 0",
                     u_if.o_valid, u_if.o_ready, u_if.o_data, u_if.o_ovf_count, u_if.o_drop);
        end else pass_cnt++;
        #2 i_rst = 1'b0;
        model_clear();
        tick();
        offer(1'b1, 6'h2A, 1'b0, 1'b0, p, h);
        tick();
        offer(1'b0, 6'h00, 1'b0, 1'b1, p, h);
        total_cnt++;
        if (!p || u_if.o_valid !== 1'b1 || {u_if.o_overflow, u_if.o_data} !== h) begin
            $display("FAIL post_reset_word: got v=%0b d=%h want 1/%h", u_if.o_valid, {u_if.o_overflow, u_if.o_data}, h);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (u_if.o_valid !== 1'b0) begin
            $display("FAIL post_reset_only_word: got valid=%0b want 0", u_if.o_valid);
        end else pass_cnt++;
    endtask

    initial begin
        i_rst            = 1'b1;
        u_if.i_valid     = 1'b0;
        u_if.i_ready     = 1'b0;
        u_if.i_data      = 6'h00;
        u_if.i_overflow  = 1'b0;
        u_if2.i_valid    = 1'b0;
        u_if2.i_ready    = 1'b0;
        u_if2.i_data     = 6'h00;
        u_if2.i_overflow = 1'b0;
        model_clear();
        test_reset();
        test_single();
        test_fill_drain();
        test_full_pop();
        test_stream();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in words; SHALL be a power of two, 2..16.
REQ-002 Parameter CNT_W, default 8, width of the overflow event counter.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high; one clock, no other clock domains.
REQ-005 i_data  input  6  result word from the producing datapath.
REQ-006 i_overflow  input  1  overflow flag belonging to i_data.
REQ-007 i_valid  input  1  producer offers i_data/i_overflow this cycle.
REQ-008 o_ready  output  1  block can accept a word this cycle.
REQ-009 o_data  output  6  head-of-FIFO result word.
REQ-010 o_overflow  output  1  overflow flag stored with the head word.
REQ-011 o_valid  output  1  head word present.
REQ-012 i_ready  input  1  consumer takes the head word this cycle.
REQ-013 o_ovf_count  output  CNT_W  count of accepted words whose overflow flag was 1.
REQ-014 o_drop  output  1  sticky flag: a word was offered while the block was full.

Function
REQ-015 Push SHALL occur on a rising edge when i_valid=1 and o_ready=1; the 7-bit entry {i_overflow, i_data} is written at the write pointer.
REQ-016 Pop SHALL occur on a rising edge when o_valid=1 and i_ready=1; the read pointer advances.
REQ-017 o_ready SHALL be 1 when occupancy < DEPTH; it SHALL depend only on registered state, never on i_ready.
REQ-018 o_valid SHALL be 1 when occupancy > 0; o_data/o_overflow SHALL show the head entry combinationally from storage (first-word-fall-through).
REQ-019 Latency: a word pushed on edge N SHALL appear at o_valid/o_data in the cycle after edge N when the FIFO was empty.
REQ-020 Push and pop on the same edge, with 0 < occupancy < DEPTH, SHALL both take effect; occupancy unchanged.
REQ-021 Full: i_valid=1 with o_ready=0 SHALL NOT write, even if a pop occurs on the same edge; o_drop SHALL set on that edge.
REQ-022 Empty: i_ready=1 with o_valid=0 SHALL be ignored; pointers and occupancy unchanged.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked exactly (0..DEPTH) with no ambiguity between full and empty.
REQ-024 o_ovf_count SHALL increment by 1 on each push with i_overflow=1 and SHALL saturate at 2^CNT_W-1.
REQ-025 o_drop SHALL remain 1 until reset.
REQ-026 Word order at the output SHALL equal acceptance order; no word SHALL be duplicated or lost except offers rejected under REQ-021.

Reset
REQ-027 i_rst=1 SHALL immediately, without a clock edge, clear pointers, occupancy, o_ovf_count and o_drop.
REQ-028 During reset: o_valid=0, o_ready=0, o_data=0, o_overflow=0, o_ovf_count=0, o_drop=0.
REQ-029 On the first rising edge after i_rst falls, o_ready SHALL be 1 and pushes SHALL be accepted.
REQ-030 Reset asserted mid-operation SHALL discard all stored words; storage contents need not be cleared, but o_data/o_overflow SHALL read 0 while o_valid=0.

Verification
REQ-031 Single word: push {ovf=0, data=6'h05}, i_ready=1 -> o_valid=1 with o_data=6'h05 the next cycle; popped on the following edge; o_valid returns to 0.
REQ-032 Fill and drain: push 6'h01..6'h04 with i_ready=0 -> o_ready=0 after the 4th push; offer 6'h05 -> o_drop=1, not stored; drain -> outputs 01,02,03,04 in order.
REQ-033 Full plus pop: full FIFO, i_valid=1 and i_ready=1 on the same edge -> one word popped, offered word not written, o_drop=1, occupancy=3.
REQ-034 Streaming wrap: continuous push/pop of 10 words 6'h00..6'h09 at occupancy 1 -> all 10 out in order, pointers wrap twice, o_ready stays 1.
REQ-035 Counter saturation with CNT_W=2: push 5 words with i_overflow=1 -> o_ovf_count reads 1,2,3,3,3.
REQ-036 Async reset: with 3 words stored, pulse i_rst between clock edges -> o_valid=0, o_ovf_count=0, o_drop=0 before the next edge; the next push is the only word delivered.
